// File: rtl/seq_sub_ctrl.sv
// Sequential nibble-serial subtractor: one 4-bit a + ~b + c slice reused LSB-first over NIB cycles.
// Optional macro SUB_SAT_EN clamps an underflowing result to zero on completion.
module seq_sub_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
  output logic [4*NIB-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int W     = 4 * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [IDX_W+1:0] bit_ofs;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_sum;
  logic             last_nib;

  // The single shared slice: {c_out, d} = a_nib + ~b_nib + c_in.
  assign bit_ofs  = {idx_q, 2'b00};
  assign a_nib    = a_q[bit_ofs +: 4];
  assign b_nib    = b_q[bit_ofs +: 4];
  assign nib_sum  = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves it unassigned (no latch).
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        diff_d[bit_ofs +: 4] = nib_sum[3:0];
        carry_d              = nib_sum[4];
        if (last_nib) begin
          bout_d = nib_sum[4];
`ifdef SUB_SAT_EN
          if (!nib_sum[4]) diff_d = '0;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_seq_sub_ctrl.sv
// Self-checking bench for seq_sub_ctrl: directed vector table, hand-written corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_seq_sub_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  seq_sub_ctrl #(.NIB(NIB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the whole word.
  function automatic logic [W-1:0] model_diff(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                              input logic mc);
    int r;
    r = int'(ma) - int'(mb) - (1 - int'(mc));
`ifdef SUB_SAT_EN
    if (r < 0) r = 0;
`endif
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic model_bout(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                      input logic mc);
    return (int'(ma) - int'(mb) - (1 - int'(mc))) >= 0;
  endfunction

  // One full operation; optionally scrambles start/operands while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit jiggle, output logic [W-1:0] got_diff, output logic got_bout,
                        output int lat, output int busy_n, output int done_n);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; lat = 0; busy_n = 0; done_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = n;
      end
      if (jiggle && busy) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    got_diff = diff;
    got_bout = bout;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input bit jiggle, input logic [W-1:0] exp_diff,
                          input logic exp_bout);
    logic [W-1:0] gd;
    logic         gb;
    int           lat, busy_n, done_n;
    run_op(ta, tb_v, tc, jiggle, gd, gb, lat, busy_n, done_n);
    check({tag, " diff"}, 32'(gd), 32'(exp_diff));
    check({tag, " bout"}, 32'(gb), 32'(exp_bout));
    check({tag, " latency"}, 32'(lat), 32'(NIB + 1));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(NIB));
    check({tag, " done_pulses"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           done_seen;

    vecs[0] = '{16'h0007, 16'h0003, 1'b1, 16'h0004, 1'b1};
    vecs[1] = '{16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1};
`ifdef SUB_SAT_EN
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'h0000, 1'b0};
    vecs[4] = '{16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
`else
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h0003, 16'h0003, 1'b0, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
`endif
    vecs[3] = '{16'h0007, 16'h0003, 1'b0, 16'h0003, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0001, 1'b1};
    vecs[8] = '{16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               vecs[i].exp_diff, vecs[i].exp_bout);
    end

    // Start re-pulsed with new operands during RUN must be ignored
    check_op("repulse", 16'h1234, 16'h0235, 1'b1, 1'b1, 16'h0FFF, 1'b1);

    // Reset in the 2nd RUN cycle aborts with no done pulse
    @(negedge clk);
    a = 16'h1234; b = 16'h0235; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy_run1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("abort partial_nib0", 32'(diff[3:0]), 32'(model_diff(16'h1234, 16'h0235, 1'b1) & 16'h000F));
    rst_n = 1'b0;
    #1;
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
      if (k == 2) rst_n = 1'b1;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    check_op("after_abort", 16'h0009, 16'h0004, 1'b1, 1'b0, 16'h0005, 1'b1);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '0;
      rc = 1'($urandom);
      check_op($sformatf("rand%0d", i), ra, rb, rc, bit'($urandom_range(0, 1)),
               model_diff(ra, rb, rc), model_bout(ra, rb, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_sub_ctrl.md
SEQ_SUB_CTRL -- requirements
Module: seq_sub_ctrl

Interface
REQ-001 The block SHALL have parameter NIB, default 4, giving the number of 4-bit slices per operand; word width W = 4*NIB.
REQ-002 The block SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a  input  W  minuend, latched on the accepted start.
REQ-006 The block SHALL have port b  input  W  subtrahend, latched on the accepted start.
REQ-007 The block SHALL have port cin  input  1  initial carry, latched on start; 1 = no borrow-in, 0 = borrow-in of 1.
REQ-008 The block SHALL have port diff  output  W  result register.
REQ-009 The block SHALL have port bout  output  1  final carry-out; 1 = no borrow (a >= b when cin=1), 0 = borrow.
REQ-010 The block SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL contain one 4-bit slice computing {c_out, d} = a_nib + ~b_nib + c_in, reused once per cycle, with no W-bit adder.
REQ-013 The state machine SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on a rising edge with start=1; that same edge SHALL latch a, b and cin, clear the nibble index to 0 and set busy=1.
REQ-015 In RUN, each edge SHALL process nibble idx (LSB first):
 - write diff[4*idx+3:4*idx];
 - store c_out as the carry for the next nibble;
 - increment idx.
REQ-016 After nibble NIB-1 is processed, the FSM SHALL go to DONE, set bout to that nibble's c_out, drop busy and raise done.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge, with done=0; done is high for exactly one cycle.
REQ-018 Latency from the start edge to the first cycle with done=1 SHALL be NIB+1 clock edges (5 for NIB=4).
REQ-019 start SHALL be ignored in RUN and DONE; the latched operands SHALL be unaffected by input changes after acceptance.
REQ-020 diff and bout SHALL hold their last values in IDLE until the next completion; partially updated diff is visible during RUN.
REQ-021 The result SHALL be modulo 2^W: diff = (a - b - (1 - cin)) mod 2^W, with bout the carry out of bit W-1.
REQ-022 The nibble index SHALL be ceil(log2(NIB)) bits wide or wider and SHALL NOT wrap while in RUN.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force the FSM to IDLE and set diff=0, bout=0, busy=0, done=0, idx=0, carry=0 and operand registers to 0.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Configuration
REQ-025 Macro SUB_SAT_EN SHALL be supported.
 - Defined: on the DONE transition with final carry 0 (underflow), diff SHALL be forced to all zeros and bout SHALL still report 0.
 - Undefined: diff SHALL keep the modulo result, with no saturation logic present.

Verification
REQ-026 NIB=4, a=7, b=3, cin=1 -> done 5 edges after start, diff=0x0004, bout=1, busy high for 4 cycles.
REQ-027 a=0x1234, b=0x0235, cin=1 -> diff=0x0FFF, bout=1, with borrow propagating across all nibbles.
REQ-028 a=0x0000, b=0x0001, cin=1 -> diff=0xFFFF, bout=0; with SUB_SAT_EN defined -> diff=0x0000, bout=0.
REQ-029 a=7, b=3, cin=0 -> diff=0x0003, bout=1; a=3, b=3, cin=0 -> diff=0xFFFF, bout=0.
REQ-030 Re-pulse start with new operands during RUN -> ignored, first result correct, exactly one done pulse.
REQ-031 Assert rst_n=0 at the 2nd RUN cycle -> all outputs 0 at once, no done pulse; after release, a=9, b=4 -> diff=0x0005, bout=1.
